// File: rtl/adam_aes_encipher_block_par_if.sv
// Bundle between the AES encipher datapath, the core wrapper,
// the round-key memory and the external S-box bank.
//   next/abort/keylen/block : control and plaintext from the wrapper
//   round/round_key         : key lookup by round index
//   sboxw/new_sboxw         : S-box lanes, lane 0 in the MSBs
//   new_block/ready/done    : state register, idle flag, result pulse
interface adam_aes_encipher_block_par_if #(
   parameter int SBOX_LANES = 1
);
   logic                    next;
   logic                    abort;
   logic [1:0]              keylen;
   logic [3:0]              round;
   logic [127:0]            round_key;
   logic [32*SBOX_LANES-1:0] sboxw;
   logic [32*SBOX_LANES-1:0] new_sboxw;
   logic [127:0]            block;
   logic [127:0]            new_block;
   logic                    ready;
   logic                    done;

   modport master (
      output next, abort, keylen, round_key, new_sboxw, block,
      input  round, sboxw, new_block, ready, done
   );

   modport slave (
      input  next, abort, keylen, round_key, new_sboxw, block,
      output round, sboxw, new_block, ready, done
   );
endinterface

// File: rtl/adam_aes_encipher_block_par.sv
// Iterative AES encipher datapath, SBOX_LANES S-box words per cycle.
// Ports: clk, reset_n (async, active-low), bus (slave side of the
//   encipher interface: start/abort, key lookup, S-box lanes, result).
module adam_aes_encipher_block_par #(
   parameter int SBOX_LANES = 1
) (
   input  logic clk,
   input  logic reset_n,
   adam_aes_encipher_block_par_if.slave bus
);
   localparam int L  = SBOX_LANES;
   localparam int S  = (L == 4) ? 1 : (L == 2) ? 2 : 4;
   localparam int LW = 32 * L;

   generate
      if (!(L == 1 || L == 2 || L == 4)) begin : g_bad_lanes
         $fatal(1, "SBOX_LANES must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_INIT,
      ST_SBOX,
      ST_MAIN
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [127:0]  r_block, w_block_nxt;
   logic [3:0]    r_round, w_round_nxt;
   logic [1:0]    r_ctr, w_ctr_nxt;
   logic [1:0]    r_keylen, w_keylen_nxt;
   logic          r_ready, w_ready_nxt;
   logic          r_done, w_done_nxt;

   logic [3:0]    w_nr;
   logic          w_last;
   logic [31:0]   w_words [4];
   logic [31:0]   w_sub_words [4];
   logic [127:0]  w_sub_block;
   logic [LW-1:0] w_sboxw;
   logic [127:0]  w_sr;
   logic [127:0]  w_mc;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Byte (row r, column c) lives at index 4c+r, MSB first.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      return {mix_col(s[127:96]), mix_col(s[95:64]),
              mix_col(s[63:32]),  mix_col(s[31:0])};
   endfunction

   // State word carried by a lane in the current S-box cycle.
   function automatic logic [1:0] lane_idx(input logic [1:0] ctr,
                                           input int lane);
      return 2'(int'(ctr) * L + lane);
   endfunction

   always_comb begin
      unique case (r_keylen)
         2'd0:    w_nr = 4'd10;
         2'd1:    w_nr = 4'd12;
         default: w_nr = 4'd14;
      endcase
   end

   assign w_last = (r_ctr == 2'(S - 1));
   assign w_sr   = shift_rows(r_block);
   assign w_mc   = mix_columns(w_sr);

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_words[i] = r_block[127-32*i -: 32];
      end
   end

   // Lanes carry the selected words out; returned words replace
   // only those positions.
   always_comb begin
      w_sboxw     = '0;
      w_sub_words = w_words;
      for (int i = 0; i < L; i++) begin
         w_sboxw[LW-32-32*i +: 32] = w_words[lane_idx(r_ctr, i)];
         w_sub_words[lane_idx(r_ctr, i)] =
            bus.new_sboxw[LW-32-32*i +: 32];
      end
   end

   assign w_sub_block = {w_sub_words[0], w_sub_words[1],
                         w_sub_words[2], w_sub_words[3]};

   always_comb begin
      w_state_nxt  = r_state;
      w_block_nxt  = r_block;
      w_round_nxt  = r_round;
      w_ctr_nxt    = r_ctr;
      w_keylen_nxt = r_keylen;
      w_ready_nxt  = r_ready;
      w_done_nxt   = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (bus.next && !bus.abort) begin
               w_keylen_nxt = bus.keylen;
               w_round_nxt  = 4'd0;
               w_ctr_nxt    = 2'd0;
               w_ready_nxt  = 1'b0;
               w_state_nxt  = ST_INIT;
            end
         end
         ST_INIT: begin
            w_block_nxt = bus.block ^ bus.round_key;
            w_round_nxt = 4'd1;
            w_ctr_nxt   = 2'd0;
            w_state_nxt = ST_SBOX;
         end
         ST_SBOX: begin
            w_block_nxt = w_sub_block;
            if (w_last) begin
               w_ctr_nxt   = 2'd0;
               w_state_nxt = ST_MAIN;
            end else begin
               w_ctr_nxt = r_ctr + 2'd1;
            end
         end
         ST_MAIN: begin
            w_round_nxt = r_round + 4'd1;
            if (r_round < w_nr) begin
               w_block_nxt = w_mc ^ bus.round_key;
               w_state_nxt = ST_SBOX;
            end else begin
               w_block_nxt = w_sr ^ bus.round_key;
               w_ready_nxt = 1'b1;
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      // Abort wins over every update in the same cycle, including
      // the final round: partial state and round are kept.
      if (bus.abort && r_state != ST_IDLE) begin
         w_state_nxt  = ST_IDLE;
         w_block_nxt  = r_block;
         w_round_nxt  = r_round;
         w_ctr_nxt    = 2'd0;
         w_keylen_nxt = r_keylen;
         w_ready_nxt  = 1'b1;
         w_done_nxt   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_block  <= '0;
         r_round  <= '0;
         r_ctr    <= '0;
         r_keylen <= '0;
         r_ready  <= 1'b1;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_block  <= w_block_nxt;
         r_round  <= w_round_nxt;
         r_ctr    <= w_ctr_nxt;
         r_keylen <= w_keylen_nxt;
         r_ready  <= w_ready_nxt;
         r_done   <= w_done_nxt;
      end
   end

   assign bus.round     = r_round;
   assign bus.sboxw     = w_sboxw;
   assign bus.new_block = r_block;
   assign bus.ready     = r_ready;
   assign bus.done      = r_done;

endmodule
